// File: rtl/br_hist_queue_if.sv
// -----------------------------------------------------------------------------
// br_hist_queue_pkg / br_hist_queue_if
//
// Purpose: resolution-state encoding shared with the direction predictor, and
// the dispatch / execute / predictor-side bundle of the branch history queue.
//
// Package:
//   br_state_e  BR_NONE / BR_PR_CORRECT / BR_PR_WRONG (BR_STATE_W bits)
//
// Interface signals (parameters BHR_W, DEPTH, TAG_W):
//   alloc_i, alloc_bhr_i, alloc_pred_i   dispatch presents a predicted branch
//   alloc_ready_o, alloc_tag_o           queue has room / tag of the accepted branch
//   resolve_i, resolve_tag_i,
//   resolve_taken_i                      execute reports a resolved branch
//   flush_i                              pipeline-wide flush
//   reslv_o, recrv_bhr_o, is_taken_o     resolution info to the predictor
//   squash_o                             mispredict recovery pulse to front end
//   count_o                              occupied entries
// Modports: master = dispatch/execute/predictor side, slave = the queue.
// -----------------------------------------------------------------------------
package br_hist_queue_pkg;
  localparam int BR_STATE_W = 2;

  typedef enum logic [BR_STATE_W-1:0] {
    BR_NONE       = 2'd0,
    BR_PR_CORRECT = 2'd1,
    BR_PR_WRONG   = 2'd2
  } br_state_e;
endpackage

interface br_hist_queue_if #(
  parameter int BHR_W = 8,
  parameter int DEPTH = 8,
  parameter int TAG_W = $clog2(DEPTH)
);
  import br_hist_queue_pkg::*;

  logic             alloc_i;
  logic [BHR_W-1:0] alloc_bhr_i;
  logic             alloc_pred_i;
  logic             alloc_ready_o;
  logic [TAG_W-1:0] alloc_tag_o;
  logic             resolve_i;
  logic [TAG_W-1:0] resolve_tag_i;
  logic             resolve_taken_i;
  logic             flush_i;
  br_state_e        reslv_o;
  logic [BHR_W-1:0] recrv_bhr_o;
  logic             is_taken_o;
  logic             squash_o;
  logic [TAG_W:0]   count_o;

  modport master (
    output alloc_i, alloc_bhr_i, alloc_pred_i,
    output resolve_i, resolve_tag_i, resolve_taken_i, flush_i,
    input  alloc_ready_o, alloc_tag_o,
    input  reslv_o, recrv_bhr_o, is_taken_o, squash_o, count_o
  );

  modport slave (
    input  alloc_i, alloc_bhr_i, alloc_pred_i,
    input  resolve_i, resolve_tag_i, resolve_taken_i, flush_i,
    output alloc_ready_o, alloc_tag_o,
    output reslv_o, recrv_bhr_o, is_taken_o, squash_o, count_o
  );
endinterface

// File: rtl/br_hist_queue.sv
// -----------------------------------------------------------------------------
// br_hist_queue
//
// Purpose: in-order queue of in-flight conditional branches. Captures each
// predicted branch's history snapshot and direction at dispatch (tag = tail
// index), checks the actual direction at resolve, reports the outcome to the
// predictor one cycle later and squashes all younger branches on a mispredict.
// Resolved entries retire in order from the head, one per cycle.
//
// Ports:
//   clk  clock, all state on rising edge
//   rst  asynchronous reset, active low
//   bus  br_hist_queue_if.slave (allocation, resolve, flush, resolution outputs)
// -----------------------------------------------------------------------------
module br_hist_queue
  import br_hist_queue_pkg::*;
#(
  parameter int BHR_W = 8,
  parameter int DEPTH = 8,
  localparam int TAG_W = $clog2(DEPTH)
) (
  input logic           clk,
  input logic           rst,
  br_hist_queue_if.slave bus
);

  // Entry state
  logic [DEPTH-1:0] valid_reg,    valid_next;
  logic [DEPTH-1:0] resolved_reg, resolved_next;
  logic [DEPTH-1:0] pred_reg,     pred_next;
  logic [BHR_W-1:0] bhr_mem [DEPTH];

  // Pointers and occupancy
  logic [TAG_W-1:0] head_reg,  head_next;
  logic [TAG_W-1:0] tail_reg,  tail_next;
  logic [TAG_W:0]   count_reg, count_next;

  // Registered resolution outputs
  br_state_e        reslv_reg;
  logic [BHR_W-1:0] recrv_bhr_reg;
  logic             is_taken_reg;
  logic             squash_reg;

  // Per-cycle decisions
  logic [TAG_W-1:0] res_tag;
  logic [TAG_W-1:0] res_age;
  logic             res_eff;
  logic             mispredict;
  logic             retire;
  logic             alloc_ready;
  logic             alloc_ok;

  assign res_tag     = bus.resolve_tag_i;
  assign res_eff     = bus.resolve_i & valid_reg[res_tag] & ~resolved_reg[res_tag] & ~bus.flush_i;
  assign mispredict  = res_eff & (bus.resolve_taken_i != pred_reg[res_tag]);
  // Resolved state is read from the register, so a branch resolved this
  // cycle can only retire from the next cycle on.
  assign retire      = valid_reg[head_reg] & resolved_reg[head_reg] & ~bus.flush_i;
  assign alloc_ready = (count_reg != (TAG_W+1)'(DEPTH));
  assign alloc_ok    = bus.alloc_i & alloc_ready & ~bus.flush_i & ~mispredict;

  // Age relative to head; pointer arithmetic wraps because DEPTH is a power of two.
  assign res_age = res_tag - head_reg;

  // Per-entry next state
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [TAG_W-1:0] age;
      logic             hit_alloc;
      logic             hit_retire;
      logic             hit_res;
      logic             kill;

      assign age        = TAG_W'(gi) - head_reg;
      assign hit_alloc  = alloc_ok & (tail_reg == TAG_W'(gi));
      assign hit_retire = retire & (head_reg == TAG_W'(gi));
      assign hit_res    = res_eff & (res_tag == TAG_W'(gi));
      // Everything strictly younger than the mispredicted branch goes away.
      assign kill       = mispredict & (age > res_age);

      assign valid_next[gi] = bus.flush_i        ? 1'b0 :
                              hit_alloc          ? 1'b1 :
                              (kill | hit_retire) ? 1'b0 :
                              valid_reg[gi];

      assign resolved_next[gi] = bus.flush_i        ? 1'b0 :
                                 hit_alloc          ? 1'b0 :
                                 (kill | hit_retire) ? 1'b0 :
                                 hit_res            ? 1'b1 :
                                 resolved_reg[gi];

      assign pred_next[gi] = hit_alloc ? bus.alloc_pred_i : pred_reg[gi];
    end
  endgenerate

  // Pointer / occupancy next state
  always_comb begin
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg;
    if (bus.flush_i) begin
      head_next  = '0;
      tail_next  = '0;
      count_next = '0;
    end else begin
      if (retire) begin
        head_next = head_reg + TAG_W'(1);
      end
      if (mispredict) begin
        tail_next  = res_tag + TAG_W'(1);
        count_next = (TAG_W+1)'(res_age) + (TAG_W+1)'(1) - (TAG_W+1)'(retire);
      end else begin
        if (alloc_ok) begin
          tail_next = tail_reg + TAG_W'(1);
        end
        count_next = count_reg + (TAG_W+1)'(alloc_ok) - (TAG_W+1)'(retire);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_reg    <= '0;
      resolved_reg <= '0;
      pred_reg     <= '0;
      head_reg     <= '0;
      tail_reg     <= '0;
      count_reg    <= '0;
    end else begin
      valid_reg    <= valid_next;
      resolved_reg <= resolved_next;
      pred_reg     <= pred_next;
      head_reg     <= head_next;
      tail_reg     <= tail_next;
      count_reg    <= count_next;
    end
  end

  // Snapshot storage; contents are only meaningful while the entry is valid,
  // so it carries no reset.
  always_ff @(posedge clk) begin
    if (alloc_ok) begin
      bhr_mem[tail_reg] <= bus.alloc_bhr_i;
    end
  end

  // Resolution outputs: one-cycle pulse after an effective resolve, zero otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reslv_reg     <= BR_NONE;
      recrv_bhr_reg <= '0;
      is_taken_reg  <= 1'b0;
      squash_reg    <= 1'b0;
    end else begin
      reslv_reg     <= res_eff ? (mispredict ? BR_PR_WRONG : BR_PR_CORRECT) : BR_NONE;
      recrv_bhr_reg <= res_eff ? bhr_mem[res_tag] : '0;
      is_taken_reg  <= res_eff & bus.resolve_taken_i;
      squash_reg    <= mispredict;
    end
  end

  assign bus.alloc_ready_o = alloc_ready;
  assign bus.alloc_tag_o   = tail_reg;
  assign bus.count_o       = count_reg;
  assign bus.reslv_o       = reslv_reg;
  assign bus.recrv_bhr_o   = recrv_bhr_reg;
  assign bus.is_taken_o    = is_taken_reg;
  assign bus.squash_o      = squash_reg;

endmodule

// File: tb/tb_br_hist_queue.sv
// -----------------------------------------------------------------------------
// tb_br_hist_queue
//
// Purpose: self-checking bench for br_hist_queue. A vector table covers fill,
// correct resolve/retire and mispredict squash; hand sequences cover
// out-of-order resolve, wrap-around mispredict, flush and asynchronous reset;
// a random phase runs against a queue-of-branches reference model.
// Ports: none (top level).
// -----------------------------------------------------------------------------
module tb_br_hist_queue;
  import br_hist_queue_pkg::*;

  localparam int BHR_W = 8;
  localparam int DEPTH = 8;

  logic clk;
  logic rst;

  br_hist_queue_if #(.BHR_W(BHR_W), .DEPTH(DEPTH)) bus ();

  br_hist_queue #(.BHR_W(BHR_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: live branches oldest first.
  typedef struct {
    logic [2:0] tag;
    bit         pred;
    logic [7:0] bhr;
    bit         resolved;
  } ent_t;

  ent_t mq[$];
  int   mhead = 0;

  // Values captured by the last step for directed checks.
  logic [2:0] pre_tag;
  logic       pre_ready;
  logic [3:0] act_count;
  logic [1:0] act_reslv;
  logic [7:0] act_bhr;
  logic       act_taken;
  logic       act_squash;

  typedef struct {
    bit         a;
    logic [7:0] b;
    bit         p;
    bit         r;
    logic [2:0] t;
    bit         tk;
    bit         f;
    logic [2:0] e_tag;
    bit         e_ready;
    logic [3:0] e_count;
    logic [1:0] e_reslv;
    logic [7:0] e_bhr;
    bit         e_squash;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock of stimulus. Entered and left at posedge+1.
  task automatic step(input bit a, input logic [7:0] b, input bit p,
                      input bit r, input logic [2:0] t, input bit tk, input bit f);
    int         k;
    bit         eff, mis, ret, acc;
    logic [2:0] ntag;
    logic [1:0] e_reslv;
    logic [7:0] e_bhr;
    bus.alloc_i         = a;
    bus.alloc_bhr_i     = b;
    bus.alloc_pred_i    = p;
    bus.resolve_i       = r;
    bus.resolve_tag_i   = t;
    bus.resolve_taken_i = tk;
    bus.flush_i         = f;
    #1;
    pre_tag   = bus.alloc_tag_o;
    pre_ready = bus.alloc_ready_o;
    ntag = 3'((mhead + mq.size()) % DEPTH);
    chk("ready", {31'd0, bus.alloc_ready_o}, {31'd0, mq.size() < DEPTH});
    chk("tag",   {29'd0, bus.alloc_tag_o}, {29'd0, ntag});
    chk("count_pre", {28'd0, bus.count_o}, 32'(mq.size()));

    // Decide this cycle's events from the pre-edge queue contents.
    k = -1;
    eff = 0;
    mis = 0;
    if (!f) begin
      foreach (mq[i]) if (mq[i].tag == t && !mq[i].resolved) k = i;
      eff = r && (k >= 0);
      mis = eff && (tk != mq[k].pred);
    end
    ret = !f && mq.size() > 0 && mq[0].resolved;
    acc = !f && a && mq.size() < DEPTH && !mis;
    e_reslv = eff ? (mis ? BR_PR_WRONG : BR_PR_CORRECT) : BR_NONE;
    e_bhr   = eff ? mq[k].bhr : 8'h00;

    @(posedge clk);
    #1;

    if (f) begin
      mq.delete();
      mhead = 0;
    end else begin
      if (eff) mq[k].resolved = 1;
      if (mis) while (mq.size() > k + 1) void'(mq.pop_back());
      if (acc) mq.push_back('{tag: ntag, pred: p, bhr: b, resolved: 0});
      if (ret) begin
        void'(mq.pop_front());
        mhead = (mhead + 1) % DEPTH;
      end
    end

    act_count  = bus.count_o;
    act_reslv  = bus.reslv_o;
    act_bhr    = bus.recrv_bhr_o;
    act_taken  = bus.is_taken_o;
    act_squash = bus.squash_o;
    chk("count",  {28'd0, act_count}, 32'(mq.size()));
    chk("reslv",  {30'd0, act_reslv}, {30'd0, e_reslv});
    chk("bhr",    {24'd0, act_bhr}, {24'd0, e_bhr});
    chk("taken",  {31'd0, act_taken}, {31'd0, eff && tk});
    chk("squash", {31'd0, act_squash}, {31'd0, mis});
  endtask

  task automatic idle();
    step(0, 8'h00, 0, 0, 3'd0, 0, 0);
  endtask

  task automatic flush();
    step(0, 8'h00, 0, 0, 3'd0, 0, 1);
  endtask

  function automatic vec_t mk(bit a, logic [7:0] b, bit p, bit r, logic [2:0] t, bit tk, bit f,
                              logic [2:0] e_tag, bit e_ready, logic [3:0] e_count,
                              logic [1:0] e_reslv, logic [7:0] e_bhr, bit e_squash);
    vec_t v;
    v.a = a; v.b = b; v.p = p; v.r = r; v.t = t; v.tk = tk; v.f = f;
    v.e_tag = e_tag; v.e_ready = e_ready; v.e_count = e_count;
    v.e_reslv = e_reslv; v.e_bhr = e_bhr; v.e_squash = e_squash;
    return v;
  endfunction

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.alloc_i = 0; bus.alloc_bhr_i = 0; bus.alloc_pred_i = 0;
    bus.resolve_i = 0; bus.resolve_tag_i = 0; bus.resolve_taken_i = 0; bus.flush_i = 0;
    rst = 1'b0;
    #12;
    // Reset values
    chk("rst_count", {28'd0, bus.count_o}, 32'd0);
    chk("rst_ready", {31'd0, bus.alloc_ready_o}, 32'd1);
    chk("rst_tag",   {29'd0, bus.alloc_tag_o}, 32'd0);
    chk("rst_reslv", {30'd0, bus.reslv_o}, {30'd0, BR_NONE});
    chk("rst_bhr",   {24'd0, bus.recrv_bhr_o}, 32'd0);
    chk("rst_taken", {31'd0, bus.is_taken_o}, 32'd0);
    chk("rst_squash",{31'd0, bus.squash_o}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // ---- vector table: fill, correct resolve/retire, mispredict squash ----
    for (int i = 0; i < 8; i++)
      vt.push_back(mk(1, 8'(i + 1), 0, 0, 0, 0, 0, 3'(i), 1, 4'(i + 1), BR_NONE, 8'h00, 0));
    vt.push_back(mk(1, 8'h09, 0, 0, 0, 0, 0, 3'd0, 0, 4'd8, BR_NONE, 8'h00, 0));     // 9th refused
    vt.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 3'd0, 0, 4'd0, BR_NONE, 8'h00, 0));     // flush
    vt.push_back(mk(1, 8'hA5, 1, 0, 0, 0, 0, 3'd0, 1, 4'd1, BR_NONE, 8'h00, 0));
    vt.push_back(mk(0, 8'h00, 0, 1, 0, 1, 0, 3'd1, 1, 4'd1, BR_PR_CORRECT, 8'hA5, 0));
    vt.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 3'd1, 1, 4'd0, BR_NONE, 8'h00, 0));     // retire
    vt.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 3'd1, 1, 4'd0, BR_NONE, 8'h00, 0));     // flush
    for (int i = 0; i < 5; i++)
      vt.push_back(mk(1, 8'(8'h10 + i), 1, 0, 0, 0, 0, 3'(i), 1, 4'(i + 1), BR_NONE, 8'h00, 0));
    vt.push_back(mk(0, 8'h00, 0, 1, 3'd2, 0, 0, 3'd5, 1, 4'd3, BR_PR_WRONG, 8'h12, 1));
    vt.push_back(mk(1, 8'h33, 0, 1, 3'd4, 1, 0, 3'd3, 1, 4'd4, BR_NONE, 8'h00, 0));  // tag4 gone

    foreach (vt[i]) begin
      step(vt[i].a, vt[i].b, vt[i].p, vt[i].r, vt[i].t, vt[i].tk, vt[i].f);
      chk($sformatf("v%0d_tag", i),    {29'd0, pre_tag},    {29'd0, vt[i].e_tag});
      chk($sformatf("v%0d_ready", i),  {31'd0, pre_ready},  {31'd0, vt[i].e_ready});
      chk($sformatf("v%0d_count", i),  {28'd0, act_count},  {28'd0, vt[i].e_count});
      chk($sformatf("v%0d_reslv", i),  {30'd0, act_reslv},  {30'd0, vt[i].e_reslv});
      chk($sformatf("v%0d_bhr", i),    {24'd0, act_bhr},    {24'd0, vt[i].e_bhr});
      chk($sformatf("v%0d_squash", i), {31'd0, act_squash}, {31'd0, vt[i].e_squash});
      $display("vec %0d: tag=%0d ready=%0d count=%0d reslv=%0d bhr=%02h squash=%0d",
               i, pre_tag, pre_ready, act_count, act_reslv, act_bhr, act_squash);
    end

    // ---- out-of-order resolve ----
    flush();
    for (int i = 0; i < 3; i++) step(1, 8'(8'h40 + i), 0, 0, 0, 0, 0);
    step(0, 8'h00, 0, 1, 3'd1, 0, 0);
    chk("ooo_t1_count", {28'd0, act_count}, 32'd3);
    idle();
    chk("ooo_hold", {28'd0, act_count}, 32'd3);
    step(0, 8'h00, 0, 1, 3'd0, 0, 0);
    chk("ooo_t0_count", {28'd0, act_count}, 32'd3);
    idle();
    chk("ooo_ret0", {28'd0, act_count}, 32'd2);
    idle();
    chk("ooo_ret1", {28'd0, act_count}, 32'd1);
    $display("ooo: done count=%0d", act_count);

    // ---- wrap-around mispredict ----
    flush();
    for (int i = 0; i < 6; i++) step(1, 8'(8'h50 + i), 1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 8'h00, 0, 1, 3'(i), 1, 0);
    idle();
    chk("wrap_empty", {28'd0, act_count}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step(1, 8'(8'h60 + i), 1, 0, 0, 0, 0);
      chk($sformatf("wrap_alloc%0d", i), {29'd0, pre_tag}, 32'((6 + i) % 8));
    end
    step(0, 8'h00, 0, 1, 3'd7, 0, 0);
    chk("wrap_count",  {28'd0, act_count}, 32'd2);
    chk("wrap_squash", {31'd0, act_squash}, 32'd1);
    chk("wrap_bhr",    {24'd0, act_bhr}, 32'h61);
    step(0, 8'h00, 0, 1, 3'd0, 1, 0);
    chk("wrap_next_tag", {29'd0, pre_tag}, 32'd0);
    chk("wrap_t0_dead",  {30'd0, act_reslv}, {30'd0, BR_NONE});
    step(0, 8'h00, 0, 1, 3'd1, 1, 0);
    chk("wrap_t1_dead",  {30'd0, act_reslv}, {30'd0, BR_NONE});
    $display("wrap: count=%0d", act_count);

    // ---- flush with simultaneous alloc and resolve ----
    flush();
    for (int i = 0; i < 5; i++) step(1, 8'(8'h70 + i), 1, 0, 0, 0, 0);
    step(1, 8'h7F, 1, 1, 3'd1, 0, 1);
    chk("fl_count",  {28'd0, act_count}, 32'd0);
    chk("fl_reslv",  {30'd0, act_reslv}, {30'd0, BR_NONE});
    chk("fl_squash", {31'd0, act_squash}, 32'd0);
    idle();
    chk("fl_tag", {29'd0, pre_tag}, 32'd0);
    $display("flush: count=%0d reslv=%0d", act_count, act_reslv);

    // ---- asynchronous reset mid-cycle ----
    step(1, 8'h81, 1, 0, 0, 0, 0);
    step(1, 8'h82, 1, 0, 0, 0, 0);
    step(0, 8'h00, 0, 1, 3'd1, 0, 0);
    chk("ar_pre_squash", {31'd0, bus.squash_o}, 32'd1);
    bus.resolve_i = 0;
    #2;
    rst = 1'b0;
    #1;
    chk("ar_count",  {28'd0, bus.count_o}, 32'd0);
    chk("ar_ready",  {31'd0, bus.alloc_ready_o}, 32'd1);
    chk("ar_tag",    {29'd0, bus.alloc_tag_o}, 32'd0);
    chk("ar_reslv",  {30'd0, bus.reslv_o}, {30'd0, BR_NONE});
    chk("ar_bhr",    {24'd0, bus.recrv_bhr_o}, 32'd0);
    chk("ar_taken",  {31'd0, bus.is_taken_o}, 32'd0);
    chk("ar_squash", {31'd0, bus.squash_o}, 32'd0);
    $display("async reset: count=%0d reslv=%0d", bus.count_o, bus.reslv_o);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    mq.delete();
    mhead = 0;

    // ---- random phase against the model ----
    for (int n = 0; n < 400; n++) begin
      bit         a, p, r, tk, f;
      logic [7:0] b;
      logic [2:0] t;
      a  = ($urandom_range(0, 9) < 7);
      b  = 8'($urandom);
      p  = 1'($urandom);
      r  = ($urandom_range(0, 9) < 6);
      tk = 1'($urandom);
      f  = ($urandom_range(0, 49) == 0);
      if (mq.size() > 0 && $urandom_range(0, 3) != 0)
        t = mq[$urandom_range(0, mq.size() - 1)].tag;
      else
        t = 3'($urandom);
      step(a, b, p, r, t, tk, f);
      $display("rnd %0d: a=%0d r=%0d t=%0d tk=%0d f=%0d -> count=%0d reslv=%0d squash=%0d",
               n, a, r, t, tk, f, act_count, act_reslv, act_squash);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
